// File: rtl/riscv_core_pkg.sv
// ============================================================
// riscv_core_pkg: shared types and constants for the RV64M execute stage
// Revision 1.0
// ============================================================
`default_nettype none

package riscv_core_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/riscv_core_div_unit_if.sv
// ============================================================
// riscv_core_div_unit_if: controller <-> divider handshake bundle
// Revision 1.0
// ============================================================
`default_nettype none

interface riscv_core_div_unit_if #(
  parameter int XLEN = 64
);

  logic [XLEN-1:0] i_div_srcA;
  logic [XLEN-1:0] i_div_srcB;
  logic [2:0]      i_div_control;
  logic            i_div_isword;
  logic            i_div_start;
  logic [XLEN-1:0] o_div_result;
  logic            o_div_dn;
  logic            o_div_busy;

  modport master (
    output i_div_srcA, i_div_srcB, i_div_control, i_div_isword, i_div_start,
    input  o_div_result, o_div_dn, o_div_busy
  );

  modport slave (
    input  i_div_srcA, i_div_srcB, i_div_control, i_div_isword, i_div_start,
    output o_div_result, o_div_dn, o_div_busy
  );

endinterface

`default_nettype wire

// File: rtl/riscv_core_div_step.sv
// ============================================================
// riscv_core_div_step: one combinational restoring-division iteration
// Revision 1.0
// ============================================================
`default_nettype none

module riscv_core_div_step
  import riscv_core_pkg::*;
#(
  parameter int XLEN = riscv_core_pkg::XLEN
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN:0]   abs_b,
  input  logic            dvd_bit,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;
  logic            fits;
  logic            unused_quo_msb;

  // One extra bit beyond the N+1 remainder keeps the trial sign unambiguous
  assign shifted = {rem, dvd_bit};
  assign trial   = shifted - {1'b0, abs_b};
  assign fits    = ~trial[XLEN+1];

  assign rem_next = fits ? trial[XLEN:0] : shifted[XLEN:0];
  assign quo_next = {quo[XLEN-2:0], fits};

  assign unused_quo_msb = quo[XLEN-1];

endmodule

`default_nettype wire

// File: rtl/riscv_core_div_unit.sv
// ============================================================
// riscv_core_div_unit: iterative radix-2 restoring divider (DIV/DIVU/REM/REMU + W)
// Revision 1.0
// ============================================================
`default_nettype none

module riscv_core_div_unit
  import riscv_core_pkg::*;
#(
  parameter int XLEN = riscv_core_pkg::XLEN
) (
  input  logic                      i_div_clk,
  input  logic                      i_div_rstn,
  riscv_core_div_unit_if.slave      div_if
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  div_state_e      state;
  div_state_e      state_next;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] abs_a;
  logic [XLEN:0]   abs_b;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo;
  logic            neg_q;
  logic            neg_r;
  logic            b_zero;
  logic            word_op;
  logic            rem_op;
  logic [XLEN-1:0] result;

  logic            signed_op;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN:0]   rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN:0]   rem_fix;
  logic [XLEN-1:0] sel_val;
  logic [XLEN-1:0] fix_val;
  logic            unused_bits;

  assign signed_op = ~div_if.i_div_control[0];
  assign a_ext = div_if.i_div_isword
               ? {{HALF{signed_op & div_if.i_div_srcA[HALF-1]}}, div_if.i_div_srcA[HALF-1:0]}
               : div_if.i_div_srcA;
  assign b_ext = div_if.i_div_isword
               ? {{HALF{signed_op & div_if.i_div_srcB[HALF-1]}}, div_if.i_div_srcB[HALF-1:0]}
               : div_if.i_div_srcB;
  assign sign_a = signed_op & a_ext[XLEN-1];
  assign sign_b = signed_op & b_ext[XLEN-1];
  assign mag_a  = sign_a ? -a_ext : a_ext;
  assign mag_b  = sign_b ? -b_ext : b_ext;

  riscv_core_div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .abs_b    (abs_b),
    .dvd_bit  (abs_a[XLEN-1]),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Divide-by-zero keeps the all-ones quotient the iteration naturally produces
  assign quo_fix = (neg_q && !b_zero) ? -quo : quo;
  assign rem_fix = neg_r ? -rem : rem;
  assign sel_val = rem_op ? rem_fix[XLEN-1:0] : quo_fix;
  assign fix_val = word_op ? {{HALF{sel_val[HALF-1]}}, sel_val[HALF-1:0]} : sel_val;

  assign unused_bits = rem_fix[XLEN] ^ div_if.i_div_control[2];

  always_ff @(posedge i_div_clk) begin
    if (!i_div_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (div_if.i_div_start) state_next = CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_div_clk) begin
    if (!i_div_rstn) begin
      cnt     <= '0;
      abs_a   <= '0;
      abs_b   <= '0;
      rem     <= '0;
      quo     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      b_zero  <= 1'b0;
      word_op <= 1'b0;
      rem_op  <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_if.i_div_start) begin
            // Word-mode dividend is left-aligned so the MSB-first shift works for both widths
            abs_a   <= div_if.i_div_isword ? (mag_a << HALF) : mag_a;
            abs_b   <= {1'b0, mag_b};
            neg_q   <= sign_a ^ sign_b;
            neg_r   <= sign_a;
            b_zero  <= (b_ext == '0);
            word_op <= div_if.i_div_isword;
            rem_op  <= div_if.i_div_control[1];
            rem     <= '0;
            quo     <= '0;
            cnt     <= div_if.i_div_isword ? CW'(HALF - 1) : CW'(XLEN - 1);
          end
        end
        CALC: begin
          rem   <= rem_next;
          quo   <= quo_next;
          abs_a <= abs_a << 1;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          result <= fix_val;
        end
        default: ;
      endcase
    end
  end

  assign div_if.o_div_result = result;
  assign div_if.o_div_dn     = (state == DONE);
  assign div_if.o_div_busy   = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_riscv_core_div_unit.sv
// ============================================================
// tb_riscv_core_div_unit: directed self-checking bench for the divider
// Revision 1.0
// ============================================================
`default_nettype none

module tb_riscv_core_div_unit;
  import riscv_core_pkg::*;

  logic clk;
  logic rstn;
  int   total;
  int   bad;
  logic [63:0] prev_result;

  riscv_core_div_unit_if #(.XLEN(64)) div_if ();

  riscv_core_div_unit #(.XLEN(64)) dut (
    .i_div_clk  (clk),
    .i_div_rstn (rstn),
    .div_if     (div_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind 0: plain op; 1: re-assert start at cycle 10; 2: reset at cycle 20
  task automatic run_op(input logic [2:0] ctl, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat,
                        input int kind, input string tag);
    int cyc;
    div_if.i_div_srcA    = a;
    div_if.i_div_srcB    = b;
    div_if.i_div_control = ctl;
    div_if.i_div_isword  = w;
    div_if.i_div_start   = 1'b1;
    @(posedge clk); #1;
    div_if.i_div_start = 1'b0;
    div_if.i_div_srcA  = 64'hDEAD_BEEF_0BAD_F00D;
    div_if.i_div_srcB  = 64'h3;
    cyc = 1;
    chk({tag, "_busy_c1"}, {63'd0, div_if.o_div_busy}, 64'd1);
    chk({tag, "_hold_c1"}, div_if.o_div_result, prev_result);
    while (div_if.o_div_dn !== 1'b1 && cyc < lat + 10) begin
      if (kind == 1 && cyc == 10) begin
        div_if.i_div_srcA    = 64'd5;
        div_if.i_div_srcB    = 64'd1;
        div_if.i_div_control = DIVU;
        div_if.i_div_isword  = 1'b1;
        div_if.i_div_start   = 1'b1;
      end else begin
        div_if.i_div_start = 1'b0;
      end
      if (kind == 2 && cyc == 20) rstn = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (rstn == 1'b0) begin
        rstn = 1'b1;
        chk({tag, "_rst_result"}, div_if.o_div_result, 64'd0);
        chk({tag, "_rst_busy"}, {63'd0, div_if.o_div_busy}, 64'd0);
        chk({tag, "_rst_dn"}, {63'd0, div_if.o_div_dn}, 64'd0);
        prev_result = 64'd0;
      end
    end
    div_if.i_div_start = 1'b0;
    if (kind == 2) begin
      chk({tag, "_no_dn"}, {63'd0, div_if.o_div_dn}, 64'd0);
    end else begin
      chk({tag, "_dn"}, {63'd0, div_if.o_div_dn}, 64'd1);
      chk({tag, "_lat"}, 64'(cyc), 64'(lat));
      chk({tag, "_busy_dn"}, {63'd0, div_if.o_div_busy}, 64'd1);
      chk({tag, "_result"}, div_if.o_div_result, exp);
      prev_result = exp;
      @(posedge clk); #1;
      chk({tag, "_dn_end"}, {63'd0, div_if.o_div_dn}, 64'd0);
      chk({tag, "_busy_end"}, {63'd0, div_if.o_div_busy}, 64'd0);
      chk({tag, "_result_hold"}, div_if.o_div_result, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    prev_result = 64'd0;
    rstn = 1'b0;
    div_if.i_div_srcA    = 64'd0;
    div_if.i_div_srcB    = 64'd0;
    div_if.i_div_control = DIV;
    div_if.i_div_isword  = 1'b0;
    div_if.i_div_start   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", div_if.o_div_result, 64'd0);
    chk("reset_dn", {63'd0, div_if.o_div_dn}, 64'd0);
    chk("reset_busy", {63'd0, div_if.o_div_busy}, 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_op(DIV,  1'b0, 64'd100, 64'd7, 64'd14, 66, 0, "div_100_7");
    run_op(REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0, "rem_m7_2");
    run_op(DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0, "div_m7_2");
    run_op(REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd5, 66, 0, "remu_max_10");
    run_op(DIVU, 1'b0, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0, "divu_by0");
    run_op(DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0, "div_m5_by0");
    run_op(REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 66, 0, "rem_m5_by0");
    run_op(DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 66, 0, "div_ovf");
    run_op(REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66, 0, "rem_ovf");
    run_op(DIV,  1'b1, 64'h0000_1234_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 34, 0, "divw_ovf");
    run_op(DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 34, 0, "divuw");
    run_op(REM,  1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 34, 0, "remw_7_m2");
    run_op(DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'h1999_9999_9999_9999, 66, 1, "restart_ign");
    run_op(DIV,  1'b0, 64'd100, 64'd7, 64'd0, 66, 2, "reset_mid");
    run_op(DIV,  1'b0, 64'd100, 64'd7, 64'd14, 66, 0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
